imm_encode: RTL and testbench
=============================

# imm_encode

Iterative immediate encoder for the single-cycle ARM datapath toolchain and self-test logic. It is the inverse of the immediate extender. It takes a 32-bit constant and an ImmSrc selector and returns the 24-bit instruction immediate field that the extender expands back to the same constant, or flags the constant as unencodable. The data-processing rotated form is found by a multi-cycle search, one rotation per cycle, behind a valid/ready handshake on both sides.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- value  input  32  constant to encode; sampled on acceptance only.
- ImmSrc  input  2  00 imm8 sign-extended; 01 imm12 zero-extended; 10 branch imm24<<2 sign-extended; 11 rotated imm8 (rot4, imm8).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- imm  output  24  encoded field, i.e. instruction bits [23:0].
- ok  output  1  1 = value encodable in the selected form; 0 = not encodable.

## Operation
- States: IDLE, EVAL, DONE.
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, imm=0, ok=0, working register=0, rotation count r=0. Reset during EVAL or DONE discards the request. No output is produced for it.
- IDLE: in_ready=1. On the edge where in_valid&in_ready, latch value into working register W, latch ImmSrc, clear r, and go to EVAL. value and ImmSrc are ignored after acceptance.
- EVAL, ImmSrc=00: ok=1 iff W[31:8] all equal W[7]; imm={16'b0,W[7:0]}. Next state is DONE.
- EVAL, ImmSrc=01: ok=1 iff W[31:12]==0; imm={12'b0,W[11:0]}. Next state is DONE.
- EVAL, ImmSrc=10: ok=1 iff W[1:0]==0 and W[31:26] all equal W[25]; imm=W[25:2]. Next state is DONE.
- EVAL, ImmSrc=11, hit test: W holds ROL(value,2r). Hit iff W[31:8]==0.
  - On hit: ok=1, imm={12'b0,r[3:0],W[7:0]}, next state DONE.
  - On miss with r<15: W<=ROL(W,2), r<=r+1, stay in EVAL.
  - On miss with r==15: ok=0, next state DONE.
  - The smallest r that hits wins.
- Whenever ok=0, imm=0.
- DONE: out_valid=1. imm and ok are held stable until out_valid&out_ready. On that edge go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
- There is no accept in the same cycle as a result handoff.
- Unused upper fields of imm are always zero.

## Timing
- Latency is counted from the accept edge to the first cycle with out_valid=1.
- ImmSrc 00/01/10: 1 cycle.
- ImmSrc 11: r+1 cycles on a hit at rotation r (1..16). A failure takes 16 cycles.
- Throughput: at most one request per latency+2 cycles with out_ready held high.
- in_ready is low from the cycle after acceptance until the cycle after handoff.
- out_valid never drops without out_ready. imm and ok never change while out_valid=1.
- Outputs are registered. No combinational path from in_valid/value to outputs, or from out_ready to in_ready.

## Test plan
- Reset release: in_ready=1, out_valid=0, imm=0, ok=0. Then ImmSrc=00, value=0xFFFFFF80 → 1 cycle later ok=1, imm=0x000080. Then value=0x00000080 → ok=0, imm=0.
- ImmSrc=01:
  - value=0x00000ABC → ok=1, imm=0x000ABC.
  - value=0x00001000 → ok=0, imm=0.
- ImmSrc=10:
  - value=0xFFFFFFF8 → ok=1, imm=0xFFFFFE.
  - value=0x00000006 → ok=0.
  - value=0x02000000 → ok=0.
- ImmSrc=11:
  - value=0x00000000 → ok=1, imm=0x000000, latency 1.
  - value=0xFF000000 → ok=1, imm=0x0004FF, latency 5.
  - value=0x00000102 → ok=0, imm=0, latency 16.
- Backpressure: ImmSrc=11, value=0xFF000000, out_ready low for 3 cycles after out_valid rises. Required response: imm and ok stay stable, in_ready stays 0. Toggling value/ImmSrc during EVAL does not change the result. Handoff is followed by in_ready=1 the next cycle.
- Reset mid-search: ImmSrc=11, value=0x00000102, assert rst_n=0 at r=7 → out_valid=0 immediately (async). After release: in_ready=1, no stale result. A new request (ImmSrc=01, value=0x123) returns imm=0x000123.

Source files
------------

// File: rtl/imm_encode.sv
// imm_encode -- inverse of the ARM immediate extender.
//
// Takes a 32-bit constant plus an ImmSrc selector and returns the 24-bit
// instruction immediate field that the extender would expand back into the
// same constant, together with an "encodable" flag. The rotated-imm8 form is
// searched iteratively, one even rotation per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   value, ImmSrc       constant and form selector, sampled on accept
//   out_valid/out_ready result handshake
//   imm                 encoded instruction bits [23:0] (zero when !ok)
//   ok                  1 = value encodable in the selected form
module imm_encode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [1:0]  ImmSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] imm,
    output logic        ok
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_w,     w_w_nxt;     // working copy: ROL(value, 2*r_rot)
    logic [1:0]  r_src,   w_src_nxt;
    logic [3:0]  r_rot,   w_rot_nxt;
    logic [23:0] r_imm,   w_imm_nxt;
    logic        r_ok,    w_ok_nxt;

    logic        w_ok8, w_ok12, w_ok24, w_hit;

    // Form checks on the working register.
    assign w_ok8  = (r_w[31:8]  == {24{r_w[7]}});
    assign w_ok12 = (r_w[31:12] == 20'd0);
    assign w_ok24 = (r_w[1:0] == 2'b00) && (r_w[31:26] == {6{r_w[25]}});
    assign w_hit  = (r_w[31:8]  == 24'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_w     <= '0;
            r_src   <= '0;
            r_rot   <= '0;
            r_imm   <= '0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_src   <= w_src_nxt;
            r_rot   <= w_rot_nxt;
            r_imm   <= w_imm_nxt;
            r_ok    <= w_ok_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_src_nxt   = r_src;
        w_rot_nxt   = r_rot;
        w_imm_nxt   = r_imm;
        w_ok_nxt    = r_ok;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_w_nxt     = value;
                    w_src_nxt   = ImmSrc;
                    w_rot_nxt   = 4'd0;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                w_state_nxt = DONE;
                case (r_src)
                    2'b00: begin
                        w_ok_nxt  = w_ok8;
                        w_imm_nxt = w_ok8 ? {16'd0, r_w[7:0]} : 24'd0;
                    end
                    2'b01: begin
                        w_ok_nxt  = w_ok12;
                        w_imm_nxt = w_ok12 ? {12'd0, r_w[11:0]} : 24'd0;
                    end
                    2'b10: begin
                        w_ok_nxt  = w_ok24;
                        w_imm_nxt = w_ok24 ? r_w[25:2] : 24'd0;
                    end
                    default: begin
                        // Rotations are tried in increasing order, so the
                        // first hit is the smallest rotation.
                        if (w_hit) begin
                            w_ok_nxt  = 1'b1;
                            w_imm_nxt = {12'd0, r_rot, r_w[7:0]};
                        end else if (r_rot == 4'd15) begin
                            w_ok_nxt  = 1'b0;
                            w_imm_nxt = 24'd0;
                        end else begin
                            w_w_nxt     = {r_w[29:0], r_w[31:30]};
                            w_rot_nxt   = r_rot + 4'd1;
                            w_state_nxt = EVAL;
                        end
                    end
                endcase
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign imm       = r_imm;
    assign ok        = r_ok;

endmodule

// File: tb/tb_imm_encode.sv
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] value = '0;
    logic [1:0]  ImmSrc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] imm;
    logic        ok;

    imm_encode dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .value(value), .ImmSrc(ImmSrc),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .ok(ok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] imm;
        logic        ok;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    // Monitor: pops an expectation on each new result and checks hold
    // behaviour while the result is stalled.
    logic prev_v = 1'b0;
    logic prev_h = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_h = 1'b0;
        end else begin
            if (prev_h) begin
                chk("post_handoff_in_ready", {31'd0, in_ready}, 32'd1);
                chk("post_handoff_out_valid", {31'd0, out_valid}, 32'd0);
            end
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output imm=%h ok=%b", imm, ok);
                end else begin
                    cur = sb.pop_front();
                    chk("imm", {8'd0, imm}, {8'd0, cur.imm});
                    chk("ok", {31'd0, ok}, {31'd0, cur.ok});
                    chk("latency", cyc - cur.acc - 1, cur.lat);
                end
            end else if (out_valid) begin
                chk("hold_imm", {8'd0, imm}, {8'd0, cur.imm});
                chk("hold_ok", {31'd0, ok}, {31'd0, cur.ok});
                chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
            end
            prev_v = out_valid;
            prev_h = out_valid && out_ready;
        end
    end

    // Driver steps land 2ns after the falling edge so they never race the
    // monitor's sampling.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic issue_only(input logic [1:0] src, input logic [31:0] v);
        in_valid = 1'b1;
        value    = v;
        ImmSrc   = src;
        step();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] src, input logic [31:0] v,
                         input logic [23:0] eimm, input logic eok, input int elat);
        exp_t e;
        e.imm = eimm;
        e.ok  = eok;
        e.lat = elat;
        e.acc = cyc;
        sb.push_back(e);
        issue_only(src, v);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready || out_valid) && n < 80) begin
            step();
            n++;
        end
        if (n >= 80) begin
            total++;
            bad++;
            $display("FAIL timeout_wait_idle pending=%0d in_ready=%b", sb.size(), in_ready);
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] src, input logic [31:0] v,
                       input logic [23:0] eimm, input logic eok, input int elat);
        issue(src, v, eimm, eok, elat);
        wait_idle();
        step();
    endtask

    initial begin
        int n;
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imm", {8'd0, imm}, 32'd0);
        chk("rst_ok", {31'd0, ok}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

        run(2'b00, 32'hFFFFFF80, 24'h000080, 1'b1, 1);
        run(2'b00, 32'h00000080, 24'h000000, 1'b0, 1);
        run(2'b01, 32'h00000ABC, 24'h000ABC, 1'b1, 1);
        run(2'b01, 32'h00001000, 24'h000000, 1'b0, 1);
        run(2'b10, 32'hFFFFFFF8, 24'hFFFFFE, 1'b1, 1);
        run(2'b10, 32'h00000006, 24'h000000, 1'b0, 1);
        run(2'b10, 32'h02000000, 24'h000000, 1'b0, 1);
        run(2'b11, 32'h00000000, 24'h000000, 1'b1, 1);
        run(2'b11, 32'h000000AB, 24'h0000AB, 1'b1, 1);
        run(2'b11, 32'hFF000000, 24'h0004FF, 1'b1, 5);
        run(2'b11, 32'h000003FC, 24'h000FFF, 1'b1, 16);
        run(2'b11, 32'h00000102, 24'h000000, 1'b0, 16);

        // Backpressure with input churn during the search.
        out_ready = 1'b0;
        issue(2'b11, 32'hFF000000, 24'h0004FF, 1'b1, 5);
        n = 0;
        while (!out_valid && n < 40) begin
            value  = $urandom;
            ImmSrc = 2'($urandom_range(0, 3));
            step();
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL timeout_bp_valid out_valid=%b", out_valid);
        end
        repeat (3) begin
            value = $urandom;
            step();
        end
        chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_idle();
        step();

        // Asynchronous reset in the middle of a failing search.
        issue_only(2'b11, 32'h00000102);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_ok", {31'd0, ok}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (20) begin
            step();
            if (out_valid) begin
                total++;
                bad++;
                $display("FAIL stale_result imm=%h ok=%b", imm, ok);
            end
        end
        chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run(2'b01, 32'h00000123, 24'h000123, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
